data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the memory address width (32 words).
REQ-002 Parameter DATA_W, default 8, SHALL set the memory data width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 clear  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 a_req  input  1  Port A access request; held high until a_ack.
REQ-006 a_we  input  1  Port A: 1 = write, 0 = read; stable while a_req is high.
REQ-007 a_addr  input  ADDR_W  Port A word address; stable while a_req is high.
REQ-008 a_wdata  input  DATA_W  Port A write data; stable while a_req is high.
REQ-009 a_ack  output  1  Port A single-cycle completion pulse.
REQ-010 a_rdata  output  DATA_W  Port A registered read data; valid when a_ack is high, held until the next port A read completes.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata SHALL mirror REQ-005..REQ-010 for port B.
REQ-012 mem_read  output  1  Read strobe to the data memory.
REQ-013 mem_write  output  1  Write strobe to the data memory.
REQ-014 mem_addr  output  ADDR_W  Memory address.
REQ-015 mem_wdata  output  DATA_W  Memory write data.
REQ-016 mem_rdata  input  DATA_W  Memory read data, registered inside the memory and valid one cycle after the read edge.
REQ-017 busy  output  1  High in any state other than IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and CAPTURE.
REQ-019 IDLE SHALL go to ISSUE when any eligible request is present, latching the winner (owner), we, addr and wdata; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE SHALL drive mem_addr and mem_wdata from the latched values, with mem_read = !we or mem_write = we, for exactly one cycle, then go to CAPTURE.
REQ-021 mem_read and mem_write SHALL never be high in the same cycle, and both SHALL be low outside ISSUE.
REQ-022 CAPTURE SHALL, for reads, load mem_rdata into the owner's rdata register and set the owner's ack for the following cycle, then go to IDLE.
REQ-023 For writes, CAPTURE SHALL leave rdata unchanged.
REQ-024 Latency SHALL be fixed: a request sampled at edge k reaches the memory at edge k+1 and has rdata/ack set at edge k+2; ack is high during cycle k+2.
REQ-025 Throughput SHALL be at most one access per 3 cycles.
REQ-026 A port whose ack is high in the current cycle SHALL be ineligible in that IDLE cycle; this prevents double-servicing a request that is still being dropped.
REQ-027 Arbitration SHALL be round-robin with a 1-bit priority pointer: on simultaneous requests the pointed port wins, and after any grant the pointer moves to the other port.
REQ-028 A lone eligible request SHALL win regardless of the pointer.
REQ-029 Inputs SHALL be sampled only in IDLE; request field changes during ISSUE or CAPTURE SHALL have no effect on the access in progress.
REQ-030 Address arithmetic SHALL be none; addresses pass through unmodified and all 2^ADDR_W values are legal.

Reset
REQ-031 When clear is asserted, the arbiter SHALL immediately enter IDLE with the priority pointer on port A.
REQ-032 During reset, a_ack, b_ack, mem_read, mem_write and busy SHALL be 0, and a_rdata, b_rdata, mem_addr and mem_wdata SHALL be 0.
REQ-033 Reset during ISSUE or CAPTURE SHALL abort the access with no ack; the requester re-arbitrates after clear deasserts.

Structure
REQ-034 ADDR_W and DATA_W defaults, the state enum (IDLE/ISSUE/CAPTURE) and the port-select enum (PORT_A/PORT_B) SHALL live in shared package data_mem_pkg.
REQ-035 The round-robin decision SHALL be a sub-module mem_rr_arbiter2: inputs req[1:0], ptr and enable; outputs a one-hot grant and the next pointer.

Verification
REQ-036 Reset, then A read addr 3 alone -> mem_read high one cycle with mem_addr = 3; a_ack high 2 cycles after acceptance with a_rdata = 8'h03.
REQ-037 B write addr 20 data 8'h5A, then B read addr 20 -> mem_write pulse only (no mem_read); read returns b_rdata = 8'h5A; a_rdata unchanged.
REQ-038 A and B request together from reset -> A served first, B next; repeated simultaneous requests alternate A, B, A, B.
REQ-039 A holds a_req one cycle past a_ack -> no second access is issued for A; a pending B wins that IDLE slot.
REQ-040 clear asserted during ISSUE of an A read of addr 17 -> outputs reset immediately, no a_ack; after release, re-request returns 8'hFF.
REQ-041 Throughout all scenarios, check that mem_read and mem_write are never both high and that busy equals the state not being IDLE.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the two-port data memory arbiter: default widths,
// FSM state encoding and the port-select type used by the arbiter logic.
package data_mem_pkg;

   localparam int ADDR_W_DEFAULT = 5;
   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_t;

   // The round-robin pointer always moves away from the port just served.
   function automatic port_sel_t other_port(input port_sel_t p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter2.sv
// Two-requester round-robin decision. req[0] is port A, req[1] is port B.
// When both request, the port named by ptr wins; a lone request always wins.
module mem_rr_arbiter2
   import data_mem_pkg::*;
(
   input  logic [1:0] req,
   input  port_sel_t  ptr,
   input  logic       enable,
   output logic [1:0] grant,
   output port_sel_t  next_ptr
);

   // Pick the winner and the pointer that follows from it.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      grant    = 2'b00;
      next_ptr = ptr;
      if (enable) begin
         unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == PORT_A) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
         if (grant != 2'b00) begin
            next_ptr = other_port(grant[1] ? PORT_B : PORT_A);
         end
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with registered
// read data. Each access takes IDLE -> ISSUE -> CAPTURE, so the ack for a
// request accepted at edge k is visible during the cycle after edge k+2.
module data_memory_arbiter
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_t        state;
   port_sel_t         ptr;
   port_sel_t         next_ptr;
   port_sel_t         owner;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [1:0]        eligible;
   logic [1:0]        grant;

   // A port still showing its ack is dropping a finished request; skip it.
   assign eligible = {b_req & ~b_ack, a_req & ~a_ack};

   mem_rr_arbiter2 u_rr (
      .req      (eligible),
      .ptr      (ptr),
      .enable   (state == IDLE),
      .grant    (grant),
      .next_ptr (next_ptr)
   );

   // Sequence the access and latch the winning request while in IDLE.
   always_ff @(posedge clock or posedge clear) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (clear) begin
         state     <= IDLE;
         ptr       <= PORT_A;
         owner     <= PORT_A;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  state     <= ISSUE;
                  ptr       <= next_ptr;
                  owner     <= grant[1] ? PORT_B : PORT_A;
                  lat_we    <= grant[1] ? b_we    : a_we;
                  lat_addr  <= grant[1] ? b_addr  : a_addr;
                  lat_wdata <= grant[1] ? b_wdata : a_wdata;
               end
            end
            ISSUE:   state <= CAPTURE;
            CAPTURE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Capture read data into the owner's register and pulse its ack.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         a_ack <= (state == CAPTURE) && (owner == PORT_A);
         b_ack <= (state == CAPTURE) && (owner == PORT_B);
         if ((state == CAPTURE) && !lat_we) begin
            if (owner == PORT_A) a_rdata <= mem_rdata;
            else                 b_rdata <= mem_rdata;
         end
      end
   end

   // Memory strobes exist only in ISSUE; address and data come from the latch.
   assign mem_read  = (state == ISSUE) && !lat_we;
   assign mem_write = (state == ISSUE) &&  lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a registered-read memory model, table-driven
// single accesses, hand sequences for arbitration/reset corners and a
// randomized run checked against a timestamped transaction schedule.
module tb_data_memory_arbiter;

   localparam int AW      = 5;
   localparam int DW      = 8;
   localparam int RND_CYC = 600;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr, mem_addr;
   logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic          a_ack, b_ack, mem_read, mem_write, busy;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_a_rd, exp_b_rd;

   data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .clear     (clear),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack),
      .b_rdata   (b_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Memory contents after clear: word i holds i, except word 17 holds FF.
   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 17) ? 8'hFF : DW'(i);
   endfunction

   // Data memory: writes on the strobe edge, read data registered one cycle later.
   logic [DW-1:0] mem [0:31];
   always @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
         mem_rdata <= '0;
      end else begin
         if (mem_write) mem[mem_addr] <= mem_wdata;
         if (mem_read)  mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next sampling point and check strobe exclusivity.
   task automatic tick();
      @(negedge clock);
      check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
   endtask

   task automatic idle_inputs();
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      clear = 1'b1;
      idle_inputs();
      @(negedge clock);
      @(negedge clock);
      check("reset_ctrl", 32'({a_ack, b_ack, mem_read, mem_write, busy}), 32'd0);
      check("reset_data", 32'({a_rdata, b_rdata, mem_addr, mem_wdata}), 32'd0);
      clear    = 1'b0;
      exp_a_rd = '0;
      exp_b_rd = '0;
   endtask

   typedef struct {
      logic          port;       // 0 = A, 1 = B
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;  // only meaningful for reads
   } vec_t;

   // One lone request with fixed latency: strobe next cycle, ack two after that.
   task automatic run_single(input vec_t v);
      if (v.port) begin
         b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
      end else begin
         a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      end
      tick();
      check("issue_strobe", 32'({mem_read, mem_write}), 32'({!v.we, v.we}));
      check("issue_addr", 32'(mem_addr), 32'(v.addr));
      if (v.we) check("issue_wdata", 32'(mem_wdata), 32'(v.wdata));
      check("issue_busy", 32'(busy), 32'd1);
      tick();
      check("capture_quiet", 32'({mem_read, mem_write, a_ack, b_ack}), 32'd0);
      check("capture_busy", 32'(busy), 32'd1);
      tick();
      if (!v.we) begin
         if (v.port) exp_b_rd = v.exp_rdata;
         else        exp_a_rd = v.exp_rdata;
      end
      check("ack", 32'({a_ack, b_ack}), v.port ? 32'd1 : 32'd2);
      check("done_busy", 32'(busy), 32'd0);
      check("rdata", 32'({a_rdata, b_rdata}), 32'({exp_a_rd, exp_b_rd}));
      if (v.port) b_req = 1'b0;
      else        a_req = 1'b0;
      tick();
      check("ack_one_pulse", 32'({a_ack, b_ack}), 32'd0);
   endtask

   // Both ports raise a read together (A addr 1, B addr 2); record service order.
   task automatic serve_pair(input logic [AW-1:0] first_addr, input logic [AW-1:0] second_addr);
      logic [AW-1:0] got [2];
      int n = 0;
      got[0] = '0;
      got[1] = '0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_read) begin
            if (n < 2) got[n] = mem_addr;
            n++;
         end
         if (a_ack) a_req = 1'b0;
         if (b_ack) b_req = 1'b0;
      end
      check("pair_count", 32'(n), 32'd2);
      check("pair_first", 32'(got[0]), 32'(first_addr));
      check("pair_second", 32'(got[1]), 32'(second_addr));
      exp_a_rd = 8'h01;
      exp_b_rd = 8'h02;
      check("pair_rdata", 32'({a_rdata, b_rdata}), 32'({exp_a_rd, exp_b_rd}));
   endtask

   // Expected per-cycle behaviour for the random run, indexed by cycle number.
   typedef struct packed {
      logic          rd, wr, a_ack, b_ack, busy, set_a, set_b;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rval;
   } cyc_exp_t;
   cyc_exp_t ex [0:RND_CYC+4];

   task automatic random_phase();
      logic [DW-1:0] shadow [0:31];
      logic          pref_b, a_drop_next, b_drop_next, ea, eb, win_b, w_we;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_wdata;
      int            next_free, e;
      do_reset();
      for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
      for (int i = 0; i <= RND_CYC + 4; i++) ex[i] = '0;
      pref_b = 1'b0; a_drop_next = 1'b0; b_drop_next = 1'b0; next_free = 1;
      for (int c = 0; c < RND_CYC; c++) begin
         if (c != 0) tick();
         if (ex[c].set_a) exp_a_rd = ex[c].rval;
         if (ex[c].set_b) exp_b_rd = ex[c].rval;
         check("rnd_strobe", 32'({mem_read, mem_write}), 32'({ex[c].rd, ex[c].wr}));
         if (ex[c].rd || ex[c].wr) check("rnd_addr", 32'(mem_addr), 32'(ex[c].addr));
         if (ex[c].wr) check("rnd_wdata", 32'(mem_wdata), 32'(ex[c].wdata));
         check("rnd_busy", 32'(busy), 32'(ex[c].busy));
         check("rnd_ack", 32'({a_ack, b_ack}), 32'({ex[c].a_ack, ex[c].b_ack}));
         check("rnd_rdata", 32'({a_rdata, b_rdata}), 32'({exp_a_rd, exp_b_rd}));
         // Requesters: hold until ack, sometimes one extra cycle, then maybe re-request.
         if (a_drop_next) begin
            a_req = 1'b0; a_drop_next = 1'b0;
         end else if (a_req && ex[c].a_ack) begin
            if ($urandom_range(3) == 0) a_drop_next = 1'b1;
            else                        a_req = 1'b0;
         end else if (!a_req && $urandom_range(2) == 0) begin
            a_req = 1'b1; a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
         end
         if (b_drop_next) begin
            b_req = 1'b0; b_drop_next = 1'b0;
         end else if (b_req && ex[c].b_ack) begin
            if ($urandom_range(3) == 0) b_drop_next = 1'b1;
            else                        b_req = 1'b0;
         end else if (!b_req && $urandom_range(2) == 0) begin
            b_req = 1'b1; b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
         end
         // Schedule: an access accepted at edge e strobes in cycle e, acks in cycle e+2.
         e = c + 1;
         if (e >= next_free) begin
            ea = a_req && !ex[c].a_ack;
            eb = b_req && !ex[c].b_ack;
            if (ea || eb) begin
               win_b   = (ea && eb) ? pref_b : eb;
               pref_b  = !win_b;
               w_we    = win_b ? b_we    : a_we;
               w_addr  = win_b ? b_addr  : a_addr;
               w_wdata = win_b ? b_wdata : a_wdata;
               ex[e].rd      = !w_we;
               ex[e].wr      = w_we;
               ex[e].addr    = w_addr;
               ex[e].wdata   = w_wdata;
               ex[e].busy    = 1'b1;
               ex[e+1].busy  = 1'b1;
               ex[e+2].a_ack = !win_b;
               ex[e+2].b_ack = win_b;
               if (w_we) begin
                  shadow[w_addr] = w_wdata;
               end else begin
                  ex[e+2].rval  = shadow[w_addr];
                  ex[e+2].set_a = !win_b;
                  ex[e+2].set_b = win_b;
               end
               next_free = e + 3;
            end
         end
      end
      idle_inputs();
      repeat (4) tick();
   endtask

   vec_t vecs [9];

   initial begin
      vecs[0] = '{port: 1'b0, we: 1'b0, addr: 5'd3,  wdata: 8'h00, exp_rdata: 8'h03};
      vecs[1] = '{port: 1'b1, we: 1'b1, addr: 5'd20, wdata: 8'h5A, exp_rdata: 8'h00};
      vecs[2] = '{port: 1'b1, we: 1'b0, addr: 5'd20, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[3] = '{port: 1'b0, we: 1'b1, addr: 5'd0,  wdata: 8'hC3, exp_rdata: 8'h00};
      vecs[4] = '{port: 1'b0, we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp_rdata: 8'hC3};
      vecs[5] = '{port: 1'b1, we: 1'b0, addr: 5'd31, wdata: 8'h00, exp_rdata: 8'h1F};
      vecs[6] = '{port: 1'b0, we: 1'b1, addr: 5'd31, wdata: 8'hA5, exp_rdata: 8'h00};
      vecs[7] = '{port: 1'b1, we: 1'b0, addr: 5'd31, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[8] = '{port: 1'b0, we: 1'b0, addr: 5'd17, wdata: 8'h00, exp_rdata: 8'hFF};

      do_reset();
      for (int i = 0; i < 9; i++) run_single(vecs[i]);

      // Pointer returns to A on reset, then alternates; a lone A grant hands priority to B.
      do_reset();
      serve_pair(5'd1, 5'd2);
      serve_pair(5'd1, 5'd2);
      run_single('{port: 1'b0, we: 1'b0, addr: 5'd6, wdata: 8'h00, exp_rdata: 8'h06});
      serve_pair(5'd2, 5'd1);

      // A holds its request one cycle past ack: no second access for A.
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd4;
      tick();
      check("hold_issue", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd4}));
      tick();
      tick();
      check("hold_ack", 32'(a_ack), 32'd1);
      tick();
      check("hold_no_reissue", 32'({mem_read, mem_write, busy}), 32'd0);
      a_req = 1'b0;
      tick();
      check("hold_still_idle", 32'(busy), 32'd0);

      // Same, with B pending: B takes the IDLE slot after A's ack.
      a_req = 1'b1; a_addr = 5'd4;
      tick();
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd5;
      tick();
      tick();
      check("hold_b_ack_a", 32'(a_ack), 32'd1);
      tick();
      check("hold_b_wins", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd5}));
      a_req = 1'b0;
      tick();
      tick();
      check("hold_b_ack", 32'({b_ack, b_rdata}), 32'({1'b1, 8'h05}));
      b_req = 1'b0;
      exp_b_rd = 8'h05;
      tick();

      // Clear during ISSUE of an A read of 17 aborts it; the re-request returns FF.
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd17;
      tick();
      check("abort_issue", 32'({mem_read, mem_addr}), 32'({1'b1, 5'd17}));
      #2 clear = 1'b1;
      #1;
      check("abort_ctrl", 32'({a_ack, b_ack, mem_read, mem_write, busy}), 32'd0);
      check("abort_data", 32'({a_rdata, b_rdata, mem_addr, mem_wdata}), 32'd0);
      tick();
      check("abort_no_ack", 32'({a_ack, busy}), 32'd0);
      clear    = 1'b0;
      exp_a_rd = '0;
      exp_b_rd = '0;
      run_single('{port: 1'b0, we: 1'b0, addr: 5'd17, wdata: 8'h00, exp_rdata: 8'hFF});

      random_phase();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
